cache_controller: RTL and testbench

Sequencing FSM for the direct-mapped, write-back, write-allocate data cache built from `cache_line`. It sits between the pipeline MEM stage and main memory. It resolves hits in one cycle and stalls the pipeline on misses. While stalled it writes a dirty victim line back word by word, refills the line word by word, then replays the access.

---
 rtl/cache_controller_pkg.sv | 21 ++
 rtl/cache_controller.sv | 187 ++++++++++++++++++
 tb/tb_cache_controller.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// Shared geometry and state encoding for the direct-mapped, write-back data cache controller.
// Default widths give a 32-bit byte address split as tag 22 | index 6 | word 2 | byte 2.
package cache_controller_pkg;

  localparam int CC_ADDR_BITS     = 32;
  localparam int CC_WORD_BITS     = 32;
  localparam int CC_TAG_BITS      = 22;
  localparam int CC_LINE_WORDS    = 4;
  localparam int LINE_WORDS_WIDTH = $clog2(CC_LINE_WORDS);
  localparam int WORD_BYTES_WIDTH = $clog2(CC_WORD_BITS / 8);
  localparam int INDEX_BITS       = CC_ADDR_BITS - CC_TAG_BITS - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH;
  localparam int LINE_NUM         = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BACKUP = 2'd1,
    S_FILL   = 2'd2,
    S_REPLAY = 2'd3
  } cache_state_t;

endpackage

// File: rtl/cache_controller.sv
// Miss sequencer between the MEM stage and main memory: hits complete combinationally,
// misses stall while a dirty victim is written back, the line is refilled, and the access replays.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDR_BITS  = CC_ADDR_BITS,
  parameter int WORD_BITS  = CC_WORD_BITS,
  parameter int TAG_BITS   = CC_TAG_BITS,
  parameter int LINE_WORDS = CC_LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_en,
  input  logic                 cpu_we,
  input  logic                 cpu_inv,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WORD_BITS-1:0] cpu_din,
  output logic [WORD_BITS-1:0] cpu_dout,
  output logic                 cpu_stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_invalid,
  output logic [WORD_BITS-1:0] cache_din,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [WORD_BITS-1:0] cache_dout,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_BITS-1:0] mem_dout,
  input  logic [WORD_BITS-1:0] mem_din,
  input  logic                 mem_ack
);

  localparam int CNT_BITS  = $clog2(LINE_WORDS);
  localparam int BYTE_BITS = $clog2(WORD_BITS / 8);
  localparam int IDX_BITS  = ADDR_BITS - TAG_BITS - CNT_BITS - BYTE_BITS;

  cache_state_t         state_reg;
  logic [CNT_BITS-1:0]  cnt_reg;
  logic                 inv_reg;
  logic [TAG_BITS-1:0]  victim_tag_reg;

  logic [TAG_BITS-1:0]  cpu_tag;
  logic [IDX_BITS-1:0]  cpu_index;
  logic [ADDR_BITS-1:0] victim_addr;
  logic [ADDR_BITS-1:0] fill_addr;
  logic                 last_word;
  logic                 acc_req;
  logic                 miss;
  logic                 inv_clean;
  logic                 inv_dirty;
  logic                 victim_dirty;

  assign cpu_tag   = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
  assign cpu_index = cpu_addr[BYTE_BITS+CNT_BITS +: IDX_BITS];
  assign last_word = (cnt_reg == CNT_BITS'(LINE_WORDS - 1));

  // Victim tag is captured at miss time so the write-back address never depends
  // combinationally on the array's tag output, which itself follows cache_addr.
  assign victim_addr = {victim_tag_reg, cpu_index, cnt_reg, {BYTE_BITS{1'b0}}};
  assign fill_addr   = {cpu_tag, cpu_index, cnt_reg, {BYTE_BITS{1'b0}}};

  // An invalidate takes priority over a load/store presented in the same cycle.
  assign acc_req      = cpu_en & ~cpu_inv;
  assign miss         = acc_req & ~cache_hit;
  assign inv_clean    = cpu_inv & cache_hit & ~cache_dirty;
  assign inv_dirty    = cpu_inv & cache_hit & cache_dirty;
  assign victim_dirty = cache_valid & cache_dirty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      inv_reg        <= 1'b0;
      victim_tag_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (inv_dirty) begin
            state_reg      <= S_BACKUP;
            inv_reg        <= 1'b1;
            cnt_reg        <= '0;
            victim_tag_reg <= cache_tag;
          end else if (miss) begin
            state_reg      <= victim_dirty ? S_BACKUP : S_FILL;
            inv_reg        <= 1'b0;
            cnt_reg        <= '0;
            victim_tag_reg <= cache_tag;
          end
        end
        S_BACKUP: begin
          if (mem_ack) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (last_word) begin
              if (inv_reg) begin
                state_reg <= S_IDLE;
                inv_reg   <= 1'b0;
              end else begin
                state_reg <= S_FILL;
              end
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            cnt_reg <= cnt_reg + 1'b1;
            // A request withdrawn mid-miss still gets its line, but nothing is replayed.
            if (last_word) state_reg <= cpu_en ? S_REPLAY : S_IDLE;
          end
        end
        S_REPLAY: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Address and memory strobes depend only on state so memory/array responses cannot loop back.
  always_comb begin
    cache_addr = cpu_addr;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    if (!rst) begin
      cache_addr = '0;
    end else begin
      case (state_reg)
        S_BACKUP: begin
          cache_addr = victim_addr;
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = victim_addr;
        end
        S_FILL: begin
          cache_addr = fill_addr;
          mem_cs     = 1'b1;
          mem_addr   = fill_addr;
        end
        default: begin
          cache_addr = cpu_addr;
        end
      endcase
    end
  end

  always_comb begin
    cpu_dout      = '0;
    cpu_stall     = 1'b0;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_invalid = 1'b0;
    cache_din     = '0;
    mem_dout      = '0;
    if (rst) begin
      case (state_reg)
        S_IDLE: begin
          cpu_dout      = cache_dout;
          cpu_stall     = miss | inv_dirty;
          cache_edit    = acc_req & cpu_we & cache_hit;
          cache_din     = cpu_din;
          cache_invalid = inv_clean;
        end
        S_BACKUP: begin
          cpu_stall     = 1'b1;
          mem_dout      = cache_dout;
          cache_invalid = inv_reg & mem_ack & last_word;
        end
        S_FILL: begin
          cpu_stall  = 1'b1;
          cache_load = mem_ack;
          cache_din  = mem_din;
        end
        default: begin
          cpu_stall = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache array, wait-state memory,
// and a negedge monitor draining per-event expectation queues.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        cpu_we;
  logic        cpu_inv;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic [31:0] cache_addr;
  logic        cache_load;
  logic        cache_edit;
  logic        cache_invalid;
  logic [31:0] cache_din;
  logic        cache_hit;
  logic        cache_valid;
  logic        cache_dirty;
  logic [21:0] cache_tag;
  logic [31:0] cache_dout;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ack;

  int vectors = 0;
  int miscompares = 0;
  int mem_wait = 2;
  int wcnt;
  int n;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  mem_exp_t    exp_mem[$];
  wr_exp_t     exp_load[$];
  wr_exp_t     exp_edit[$];
  logic [5:0]  exp_inv[$];
  logic [31:0] exp_rd[$];

  mem_exp_t    mon_m;
  wr_exp_t     mon_w;
  logic [5:0]  mon_i;
  logic [31:0] mon_d;

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_en        (cpu_en),
    .cpu_we        (cpu_we),
    .cpu_inv       (cpu_inv),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .cpu_dout      (cpu_dout),
    .cpu_stall     (cpu_stall),
    .cache_addr    (cache_addr),
    .cache_load    (cache_load),
    .cache_edit    (cache_edit),
    .cache_invalid (cache_invalid),
    .cache_din     (cache_din),
    .cache_hit     (cache_hit),
    .cache_valid   (cache_valid),
    .cache_dirty   (cache_dirty),
    .cache_tag     (cache_tag),
    .cache_dout    (cache_dout),
    .mem_cs        (mem_cs),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_dout      (mem_dout),
    .mem_din       (mem_din),
    .mem_ack       (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache array model: 64 lines x 4 words; lines 0x40 and 0x80 hold known clean data after reset.
  logic [31:0] cdata [64][4];
  logic        cvalid [64];
  logic        cdirty [64];
  logic [21:0] ctag [64];

  assign cache_tag   = ctag[cache_addr[9:4]];
  assign cache_valid = cvalid[cache_addr[9:4]];
  assign cache_dirty = cdirty[cache_addr[9:4]];
  assign cache_hit   = cvalid[cache_addr[9:4]] && (ctag[cache_addr[9:4]] == cache_addr[31:10]);
  assign cache_dout  = cdata[cache_addr[9:4]][cache_addr[3:2]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < 64; l++) begin
        cvalid[l] <= 1'b0;
        cdirty[l] <= 1'b0;
        ctag[l]   <= '0;
        for (int w = 0; w < 4; w++) cdata[l][w] <= '0;
      end
      cvalid[4] <= 1'b1;
      cvalid[8] <= 1'b1;
      for (int w = 0; w < 4; w++) begin
        cdata[4][w] <= 32'h1111_0000 + 32'(w);
        cdata[8][w] <= 32'h2222_0000 + 32'(w);
      end
    end else begin
      if (cache_load) begin
        cdata[cache_addr[9:4]][cache_addr[3:2]] <= cache_din;
        ctag[cache_addr[9:4]]   <= cache_addr[31:10];
        cvalid[cache_addr[9:4]] <= 1'b1;
        cdirty[cache_addr[9:4]] <= 1'b0;
      end
      if (cache_edit) begin
        cdata[cache_addr[9:4]][cache_addr[3:2]] <= cache_din;
        cdirty[cache_addr[9:4]] <= 1'b1;
      end
      if (cache_invalid) begin
        cvalid[cache_addr[9:4]] <= 1'b0;
        cdirty[cache_addr[9:4]] <= 1'b0;
      end
    end
  end

  // Memory model: word k holds 0xA000_0000 | byte address; ack after mem_wait idle cycles.
  logic [31:0] mem [4096];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  assign mem_ack = mem_cs && (wcnt == mem_wait);
  assign mem_din = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (!rst) begin
      wcnt <= 0;
      for (int k = 0; k < 4096; k++) mem[k] <= pat(32'(k * 4));
    end else if (mem_cs && mem_ack) begin
      wcnt <= 0;
      if (mem_we) mem[mem_addr[13:2]] <= mem_dout;
    end else if (mem_cs) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic bad_event(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event, value %h, required none", name, act);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mem_cs && mem_ack) begin
        if (exp_mem.size() == 0) bad_event("mem_xfer", mem_addr);
        else begin
          mon_m = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(mon_m.we));
          check("mem_addr", mem_addr, mon_m.addr);
          if (mon_m.we) check("mem_dout", mem_dout, mon_m.data);
        end
      end
      if (cache_load) begin
        if (exp_load.size() == 0) bad_event("cache_load", cache_addr);
        else begin
          mon_w = exp_load.pop_front();
          check("load_addr", cache_addr, mon_w.addr);
          check("load_din", cache_din, mon_w.data);
        end
      end
      if (cache_edit) begin
        if (exp_edit.size() == 0) bad_event("cache_edit", cache_addr);
        else begin
          mon_w = exp_edit.pop_front();
          check("edit_addr", cache_addr, mon_w.addr);
          check("edit_din", cache_din, mon_w.data);
        end
      end
      if (cache_invalid) begin
        if (exp_inv.size() == 0) bad_event("cache_invalid", cache_addr);
        else begin
          mon_i = exp_inv.pop_front();
          check("inv_index", 32'(cache_addr[9:4]), 32'(mon_i));
        end
      end
      if (cpu_en && !cpu_we && !cpu_inv && !cpu_stall) begin
        if (exp_rd.size() == 0) bad_event("cpu_dout", cpu_dout);
        else begin
          mon_d = exp_rd.pop_front();
          check("cpu_dout", cpu_dout, mon_d);
        end
      end
    end
  end

  task automatic exp_read(input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back('{we: 1'b0, addr: a, data: 32'h0});
    exp_load.push_back('{addr: a, data: d});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  // Presents one request and holds it until the stall drops; returns the number of stalled cycles.
  task automatic access(input logic we, input logic inv, input logic [31:0] addr,
                        input logic [31:0] din, output int n_stall);
    @(posedge clk);
    #1;
    cpu_en   = ~inv;
    cpu_we   = we;
    cpu_inv  = inv;
    cpu_addr = addr;
    cpu_din  = din;
    n_stall  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_stall) break;
      n_stall++;
    end
    if (cpu_stall) bad_event("stall_timeout", addr);
    $display("access we=%0b inv=%0b addr=%h din=%h stalled=%0d dout=%h", we, inv, addr, din, n_stall, cpu_dout);
    @(posedge clk);
    #1;
    cpu_en  = 1'b0;
    cpu_we  = 1'b0;
    cpu_inv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    cpu_en   = 1'b1;
    cpu_we   = 1'b0;
    cpu_inv  = 1'b0;
    cpu_addr = 32'h0000_3000;
    cpu_din  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    // A missing request is presented during reset; every output must still read zero.
    check("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    check("rst_mem_cs", 32'(mem_cs), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_cache_cmds", {29'h0, cache_load, cache_edit, cache_invalid}, 32'h0);
    check("rst_cpu_dout", cpu_dout, 32'h0);
    check("rst_mem_dout", mem_dout, 32'h0);
    check("rst_cache_din", cache_din, 32'h0);
    cpu_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Load hit on preloaded clean line 0x40
    exp_rd.push_back(32'h1111_0001);
    access(1'b0, 1'b0, 32'h0000_0044, 32'h0, n);
    check("load_hit_stall", 32'(n), 32'd0);

    // Store hit, then read back
    exp_edit.push_back('{addr: 32'h0000_0048, data: 32'hDEAD_BEEF});
    access(1'b1, 1'b0, 32'h0000_0048, 32'hDEAD_BEEF, n);
    check("store_hit_stall", 32'(n), 32'd0);
    exp_rd.push_back(32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'h0000_0048, 32'h0, n);
    check("store_readback_stall", 32'(n), 32'd0);

    // Clean miss, wait 2: lookup cycle + 4*3 + 1
    exp_read(32'h0000_1000, 32'hA000_1000);
    exp_read(32'h0000_1004, 32'hA000_1004);
    exp_read(32'h0000_1008, 32'hA000_1008);
    exp_read(32'h0000_100C, 32'hA000_100C);
    exp_rd.push_back(32'hA000_1000);
    access(1'b0, 1'b0, 32'h0000_1000, 32'h0, n);
    check("clean_miss_stall", 32'(n - 1), 32'd13);

    // Dirty miss: old line 0x40 written back, 0x1040 refilled, store replayed
    exp_write(32'h0000_0040, 32'h1111_0000);
    exp_write(32'h0000_0044, 32'h1111_0001);
    exp_write(32'h0000_0048, 32'hDEAD_BEEF);
    exp_write(32'h0000_004C, 32'h1111_0003);
    exp_read(32'h0000_1040, 32'hA000_1040);
    exp_read(32'h0000_1044, 32'hA000_1044);
    exp_read(32'h0000_1048, 32'hA000_1048);
    exp_read(32'h0000_104C, 32'hA000_104C);
    exp_edit.push_back('{addr: 32'h0000_1040, data: 32'h1234_5678});
    access(1'b1, 1'b0, 32'h0000_1040, 32'h1234_5678, n);
    check("dirty_miss_stall", 32'(n - 1), 32'd25);
    check("wb_mem_0x48", mem[18], 32'hDEAD_BEEF);
    check("wb_mem_0x4C", mem[19], 32'h1111_0003);
    exp_rd.push_back(32'h1234_5678);
    access(1'b0, 1'b0, 32'h0000_1040, 32'h0, n);
    check("dirty_line_hit_stall", 32'(n), 32'd0);

    // Invalidate of a clean hit: single-cycle pulse, no stall
    exp_inv.push_back(6'd0);
    access(1'b0, 1'b1, 32'h0000_1008, 32'h0, n);
    check("inv_clean_stall", 32'(n), 32'd0);

    // Invalidate of a dirty hit: 4 write-backs then the invalidate pulse
    exp_write(32'h0000_1040, 32'h1234_5678);
    exp_write(32'h0000_1044, 32'hA000_1044);
    exp_write(32'h0000_1048, 32'hA000_1048);
    exp_write(32'h0000_104C, 32'hA000_104C);
    exp_inv.push_back(6'd4);
    access(1'b0, 1'b1, 32'h0000_1044, 32'h0, n);
    check("inv_dirty_stall", 32'(n - 1), 32'd12);

    // Following load misses; zero-wait memory gives lookup + 4*1 + 1
    mem_wait = 0;
    exp_read(32'h0000_1040, 32'h1234_5678);
    exp_read(32'h0000_1044, 32'hA000_1044);
    exp_read(32'h0000_1048, 32'hA000_1048);
    exp_read(32'h0000_104C, 32'hA000_104C);
    exp_rd.push_back(32'hA000_1044);
    access(1'b0, 1'b0, 32'h0000_1044, 32'h0, n);
    check("post_inv_miss_stall", 32'(n - 1), 32'd5);

    // Reset asserted while the second fill word is outstanding
    mem_wait = 2;
    exp_read(32'h0000_2000, 32'hA000_2000);
    @(posedge clk);
    #1;
    cpu_en   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_2000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_addr == 32'h0000_2004) break;
    end
    check("fill_word2_addr", mem_addr, 32'h0000_2004);
    rst = 1'b0;
    #1;
    check("async_rst_mem_cs", 32'(mem_cs), 32'h0);
    check("async_rst_cpu_stall", 32'(cpu_stall), 32'h0);
    check("async_rst_load", 32'(cache_load), 32'h0);
    cpu_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_rd.push_back(32'h2222_0001);
    access(1'b0, 1'b0, 32'h0000_0084, 32'h0, n);
    check("post_rst_hit_stall", 32'(n), 32'd0);

    repeat (2) @(posedge clk);
    check("left_mem", 32'(exp_mem.size()), 32'd0);
    check("left_load", 32'(exp_load.size()), 32'd0);
    check("left_edit", 32'(exp_edit.size()), 32'd0);
    check("left_inv", 32'(exp_inv.size()), 32'd0);
    check("left_rd", 32'(exp_rd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
